adc_uart_streamer: RTL and testbench
====================================

ADC_UART_STREAMER -- requirements
Module: adc_uart_streamer

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 16, the ADC sample width; elaboration SHALL fail for any other value.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 434, the UART bit period in clk cycles; elaboration SHALL fail if it is less than 2.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, the sample buffer depth; elaboration SHALL fail unless it is a power of two ≥2.
REQ-004 SHALL have parameter SYNC_BYTE, default 8'hA5, the frame header byte.
REQ-005 SHALL have ports, in order:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  asynchronous active-low reset.
- sample_in  in  SAMPLE_WIDTH  ADC sample from the decimator output.
- sample_valid  in  1  one-cycle strobe qualifying sample_in.
- clear_overflow  in  1  clears overflow.
- uart_tx  out  1  8N1 serial line, idle high.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- overflow  out  1  sticky flag for a dropped sample.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-006 On sample_valid high with fifo_level<FIFO_DEPTH, the block SHALL write sample_in into the FIFO at that edge.
REQ-007 On sample_valid high with fifo_level==FIFO_DEPTH and no pop in the same cycle, the block SHALL drop the sample and set overflow.
REQ-008 A push and a pop in the same cycle SHALL both succeed, leaving fifo_level unchanged, including when the FIFO is full.
REQ-009 Each sample SHALL be sent as a 3-byte frame, in order: SYNC_BYTE, sample[15:8], sample[7:0].
REQ-010 Each byte SHALL be sent 8N1, LSB first: one start bit (0), 8 data bits, one stop bit (1), each lasting exactly CLKS_PER_BIT cycles.
REQ-011 The frame FSM states SHALL be IDLE, START, DATA, STOP; the transitions are:
- IDLE→START when the FIFO is non-empty.
- START→DATA after CLKS_PER_BIT cycles.
- DATA→STOP after 8 bits.
- STOP→START if the byte index is below 2, otherwise STOP→IDLE.
REQ-012 The FIFO pop SHALL occur on the IDLE→START transition; the popped sample SHALL be latched for the whole frame.
REQ-013 Latency: with the FIFO empty and the FSM idle, sample_valid at edge N SHALL drive uart_tx low starting at edge N+2.
REQ-014 Back-to-back frames SHALL have no idle gap: the next start bit SHALL follow the previous stop bit directly when the FIFO is non-empty at the end of STOP.
REQ-015 overflow SHALL clear when clear_overflow is high; a simultaneous set SHALL take priority over the clear.
REQ-016 busy SHALL equal (state!=IDLE) OR (fifo_level!=0), driven from registers.
REQ-017 uart_tx SHALL be a registered output with no combinational path from any input.

Reset
REQ-018 While rst_n is low, the block SHALL hold:
- uart_tx=1, busy=0, overflow=0, fifo_level=0.
- FSM=IDLE; bit counter, byte index and FIFO pointers at 0.
REQ-019 Reset asserted mid-frame SHALL abort the frame at once, drive uart_tx high and discard the FIFO contents.
REQ-020 Reset deassertion is assumed synchronized externally; the first frame SHALL start no earlier than the first sample_valid after release.

Structure
REQ-021 Package sdm_uart_pkg SHALL hold:
- the FSM state enum (IDLE, START, DATA, STOP).
- FRAME_BYTES=3.
- UART_DATA_BITS=8.
REQ-022 Single-byte serialization (START/DATA/STOP timing, baud counter) SHALL be a sub-module named uart_byte_tx with handshake byte_valid/byte_ready.
REQ-023 The FIFO and frame sequencing SHALL live in adc_uart_streamer.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-024 Single sample 16'h1234 → line carries A5,12,34 over 120 cycles; the A5 data bits read 1,0,1,0,0,1,0,1; uart_tx is low at N+2; busy drops after the final stop bit.
REQ-025 Five strobes 0x0001..0x0005 one cycle apart while idle → first popped, next four buffered; no overflow; 15 contiguous bytes follow with no idle gaps.
REQ-026 Six strobes while a frame is in progress and the FIFO is full → sixth dropped; overflow=1 until clear_overflow; later frames omit the dropped value.
REQ-027 Push on the pop cycle with the FIFO full → fifo_level stays 4; overflow=0.
REQ-028 rst_n pulsed low during DATA of byte 2 → uart_tx=1 immediately; fifo_level=0; the next sample produces a clean frame.
REQ-029 clear_overflow and an overflow event in the same cycle → overflow=1.

Source files
------------

// File: rtl/sdm_uart_pkg.sv
// Shared types and constants for the ADC sample UART streamer.
package sdm_uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_e;

   localparam int FRAME_BYTES    = 3;
   localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/adc_uart_streamer_if.sv
// Byte handshake between the frame sequencer and the byte serializer.
// A byte transfers on any clk edge where byte_valid && byte_ready; byte_data is
// stable while byte_valid is high, and byte_ready never depends on byte_valid.
interface adc_uart_streamer_if;
   logic       byte_valid;
   logic       byte_ready;
   logic [7:0] byte_data;

   modport master (output byte_valid, output byte_data, input byte_ready);
   modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 serializer for one byte: start bit, 8 data bits LSB first, stop bit.
module uart_byte_tx
   import sdm_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic                 clk,
   input  logic                 rst_n,
   adc_uart_streamer_if.slave   byte_if,
   output logic                 uart_tx_o,
   output tx_state_e            state_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(UART_DATA_BITS);

   tx_state_e       state_q;
   logic [CW-1:0]   baud_cnt_q;
   logic [BW-1:0]   bit_cnt_q;
   logic [7:0]      shift_q;
   logic            tx_q;
   logic            baud_end;
   logic            line_bit;

   assign baud_end = (baud_cnt_q == CW'(CLKS_PER_BIT - 1));

   // Accepting in the last STOP cycle lets the next start bit follow with no gap.
   assign byte_if.byte_ready = (state_q == IDLE) || ((state_q == STOP) && baud_end);

   always_comb begin
      line_bit = 1'b1;
      case (state_q)
         START:   line_bit = 1'b0;
         DATA:    line_bit = shift_q[0];
         default: line_bit = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
      end else begin
         // The line is the state's bit delayed one clock, so it carries no input path.
         tx_q <= line_bit;
         case (state_q)
            IDLE: begin
               baud_cnt_q <= '0;
               if (byte_if.byte_valid) begin
                  state_q <= START;
                  shift_q <= byte_if.byte_data;
               end
            end
            START: begin
               if (baud_end) begin
                  baud_cnt_q <= '0;
                  bit_cnt_q  <= '0;
                  state_q    <= DATA;
               end else begin
                  baud_cnt_q <= baud_cnt_q + CW'(1);
               end
            end
            DATA: begin
               if (baud_end) begin
                  baud_cnt_q <= '0;
                  shift_q    <= {1'b0, shift_q[7:1]};
                  if (bit_cnt_q == BW'(UART_DATA_BITS - 1)) begin
                     bit_cnt_q <= '0;
                     state_q   <= STOP;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BW'(1);
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q + CW'(1);
               end
            end
            STOP: begin
               if (baud_end) begin
                  baud_cnt_q <= '0;
                  if (byte_if.byte_valid) begin
                     state_q <= START;
                     shift_q <= byte_if.byte_data;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q + CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign uart_tx_o = tx_q;
   assign state_o   = state_q;

endmodule

// File: rtl/adc_uart_streamer.sv
// Buffers ADC samples in a small FIFO and streams each one over UART as a
// 3-byte frame: sync byte, sample high byte, sample low byte.
module adc_uart_streamer
   import sdm_uart_pkg::*;
#(
   parameter int         SAMPLE_WIDTH = 16,
   parameter int         CLKS_PER_BIT = 434,
   parameter int         FIFO_DEPTH   = 4,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [SAMPLE_WIDTH-1:0]       sample_in,
   input  logic                          sample_valid,
   input  logic                          clear_overflow,
   output logic                          uart_tx,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;

   if (SAMPLE_WIDTH != 16) begin : g_bad_sample_width
      $error("SAMPLE_WIDTH must be 16");
   end
   if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("CLKS_PER_BIT must be at least 2");
   end
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
      $error("FIFO_DEPTH must be a power of two >= 2");
   end

   logic [SAMPLE_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]           level_q, level_d;
   logic [1:0]              byte_idx_q, byte_idx_d;
   logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
   logic                    overflow_q, overflow_d;
   logic                    busy_q;
   logic                    fifo_full, fifo_empty;
   logic                    handshake, pop, push, drop;
   logic [7:0]              byte_data;
   tx_state_e               tx_state;

   adc_uart_streamer_if byte_if ();

   uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_tx (
      .clk       (clk),
      .rst_n     (rst_n),
      .byte_if   (byte_if),
      .uart_tx_o (uart_tx),
      .state_o   (tx_state)
   );

   assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
   assign fifo_empty = (level_q == '0);

   // byte_idx_q names the next byte to hand over; index 0 needs a fresh sample.
   assign byte_if.byte_valid = (byte_idx_q != 2'd0) || !fifo_empty;
   assign byte_if.byte_data  = byte_data;

   always_comb begin
      byte_data = SYNC_BYTE;
      case (byte_idx_q)
         2'd1:    byte_data = sample_q[15:8];
         2'd2:    byte_data = sample_q[7:0];
         default: byte_data = SYNC_BYTE;
      endcase
   end

   assign handshake = byte_if.byte_valid && byte_if.byte_ready;
   assign pop       = handshake && (byte_idx_q == 2'd0);
   assign push      = sample_valid && (!fifo_full || pop);
   assign drop      = sample_valid && fifo_full && !pop;

   always_comb begin
      level_d    = level_q;
      byte_idx_d = byte_idx_q;
      sample_d   = pop ? mem_q[rd_ptr_q] : sample_q;
      overflow_d = drop ? 1'b1 : (clear_overflow ? 1'b0 : overflow_q);
      if (push && !pop) level_d = level_q + LW'(1);
      if (pop && !push) level_d = level_q - LW'(1);
      if (handshake) begin
         byte_idx_d = (byte_idx_q == 2'(FRAME_BYTES - 1)) ? 2'd0 : byte_idx_q + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         byte_idx_q <= 2'd0;
         sample_q   <= '0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         level_q    <= level_d;
         byte_idx_q <= byte_idx_d;
         sample_q   <= sample_d;
         overflow_q <= overflow_d;
         // Registered like uart_tx, so busy falls as the last stop bit ends.
         busy_q     <= (tx_state != IDLE) || (level_q != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= sample_in;
   end

   assign busy       = busy_q;
   assign overflow   = overflow_q;
   assign fifo_level = level_q;

endmodule

// File: tb/tb_adc_uart_streamer.sv
// Directed bench for adc_uart_streamer with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_adc_uart_streamer;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int LW    = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [15:0]   sample_in = '0;
   logic          sample_valid = 1'b0;
   logic          clear_overflow = 1'b0;
   logic          uart_tx;
   logic          busy;
   logic          overflow;
   logic [LW-1:0] fifo_level;

   int            n_cmp = 0;
   int            n_err = 0;
   int            cyc = 0;
   logic [7:0]    exp_q[$];
   int            rx_start_q[$];

   adc_uart_streamer #(
      .SAMPLE_WIDTH (16),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH),
      .SYNC_BYTE    (8'hA5)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .sample_in      (sample_in),
      .sample_valid   (sample_valid),
      .clear_overflow (clear_overflow),
      .uart_tx        (uart_tx),
      .busy           (busy),
      .overflow       (overflow),
      .fifo_level     (fifo_level)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic expect_frame(input logic [15:0] v);
      exp_q.push_back(8'hA5);
      exp_q.push_back(v[15:8]);
      exp_q.push_back(v[7:0]);
   endtask

   // Returns at the negedge right after the push edge.
   task automatic push_sample(input logic [15:0] v, output int t);
      @(negedge clk);
      sample_in    = v;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      t = cyc;
   endtask

   task automatic strobe_run(input logic [15:0] base, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         sample_in    = base + 16'(k);
         sample_valid = 1'b1;
      end
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         if (busy === 1'b0) break;
      end
      repeat (8) @(negedge clk);
      check({tag, "_idle"}, busy, 0);
      check({tag, "_drain"}, exp_q.size(), 0);
   endtask

   // Line receiver: samples each bit in its middle, scores completed bytes.
   initial begin : rx_monitor
      logic [7:0] b;
      logic       ab;
      logic       stop;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && uart_tx === 1'b0) begin
            ab = 1'b0;
            b  = '0;
            rx_start_q.push_back(cyc);
            for (int c = 0; c < 2; c++) begin
               @(negedge clk);
               if (!rst_n) ab = 1'b1;
            end
            for (int i = 0; i < 8; i++) begin
               for (int c = 0; c < CPB; c++) begin
                  @(negedge clk);
                  if (!rst_n) ab = 1'b1;
               end
               b[i] = uart_tx;
            end
            for (int c = 0; c < CPB; c++) begin
               @(negedge clk);
               if (!rst_n) ab = 1'b1;
            end
            stop = uart_tx;
            if (!ab) begin
               check("rx_stop_bit", stop, 1);
               check("rx_pending", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) check("rx_byte", b, exp_q.pop_front());
            end else begin
               void'(rx_start_q.pop_back());
            end
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int         t;
      logic [7:0] a5;
      a5 = 8'hA5;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_uart_tx", uart_tx, 1);
      check("rst_busy", busy, 0);
      check("rst_overflow", overflow, 0);
      check("rst_fifo_level", fifo_level, 0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("post_rst_line_idle", uart_tx, 1);
      check("post_rst_busy", busy, 0);

      // Single sample: latency, A5 bit order, busy drop timing
      expect_frame(16'h1234);
      push_sample(16'h1234, t);
      check("t1_level_n", fifo_level, 1);
      check("t1_tx_n", uart_tx, 1);
      @(negedge clk);
      check("t1_tx_n1", uart_tx, 1);
      check("t1_level_n1", fifo_level, 0);
      check("t1_busy_n1", busy, 1);
      @(negedge clk);
      check("t1_tx_low_n2", uart_tx, 0);
      repeat (5) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("t1_a5_bit%0d", i), uart_tx, a5[i]);
         if (i < 7) repeat (CPB) @(negedge clk);
      end
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (busy === 1'b0) break;
      end
      check("t1_busy_drop_cycle", cyc - t, 122);
      wait_idle("t1");

      // Five strobes while idle: one popped, four buffered, 15 gapless bytes
      rx_start_q.delete();
      for (int k = 1; k <= 5; k++) expect_frame(16'(k));
      strobe_run(16'h0001, 5);
      check("t2_level_full", fifo_level, 4);
      check("t2_no_overflow", overflow, 0);
      wait_idle("t2");
      check("t2_byte_count", rx_start_q.size(), 15);
      for (int i = 1; i < rx_start_q.size(); i++) begin
         check($sformatf("t2_gap%0d", i), rx_start_q[i] - rx_start_q[i-1], 40);
      end

      // Six strobes: sixth hits a full FIFO mid-frame and is dropped
      for (int k = 0; k < 5; k++) expect_frame(16'h0011 + 16'(k));
      strobe_run(16'h0011, 6);
      check("t3_overflow_set", overflow, 1);
      check("t3_level_full", fifo_level, 4);
      repeat (20) @(negedge clk);
      check("t3_overflow_sticky", overflow, 1);
      clear_overflow = 1'b1;
      @(negedge clk);
      clear_overflow = 1'b0;
      check("t3_overflow_cleared", overflow, 0);
      wait_idle("t3");

      // Push on the pop edge with the FIFO full
      for (int k = 0; k < 6; k++) expect_frame(16'h0021 + 16'(k));
      strobe_run(16'h0021, 5);
      check("t4_level_full", fifo_level, 4);
      repeat (116) @(negedge clk);
      check("t4_level_before_pop", fifo_level, 4);
      sample_in    = 16'h0026;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      check("t4_level_push_pop", fifo_level, 4);
      check("t4_no_overflow", overflow, 0);
      wait_idle("t4");

      // Clear and overflow event on the same edge: set wins
      for (int k = 0; k < 5; k++) expect_frame(16'h0031 + 16'(k));
      strobe_run(16'h0031, 5);
      @(negedge clk);
      sample_in      = 16'h0036;
      sample_valid   = 1'b1;
      clear_overflow = 1'b1;
      @(negedge clk);
      sample_valid   = 1'b0;
      clear_overflow = 1'b0;
      check("t5_set_beats_clear", overflow, 1);
      clear_overflow = 1'b1;
      @(negedge clk);
      clear_overflow = 1'b0;
      check("t5_overflow_cleared", overflow, 0);
      wait_idle("t5");

      // Reset during DATA of the third byte, then a clean frame
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h41);
      push_sample(16'h4142, t);
      push_sample(16'h4344, t);
      repeat (85) @(negedge clk);
      check("t6_pre_reset_line", uart_tx, 0);
      rst_n = 1'b0;
      #1;
      check("t6_reset_line_high", uart_tx, 1);
      check("t6_reset_level", fifo_level, 0);
      check("t6_reset_busy", busy, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      check("t6_after_reset_level", fifo_level, 0);
      check("t6_after_reset_busy", busy, 0);
      check("t6_after_reset_drain", exp_q.size(), 0);
      expect_frame(16'h5566);
      push_sample(16'h5566, t);
      @(negedge clk);
      check("t6_tx_n1", uart_tx, 1);
      @(negedge clk);
      check("t6_tx_low_n2", uart_tx, 0);
      wait_idle("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
